// File: rtl/reg_hazard_pkg.sv
// rtl/reg_hazard_pkg.sv - shared constants and tag-slot type for reg_hazard_unit
//
// Purpose : register-index constants, forward-select encodings, the tag-slot
//           record tracked through EX/MEM/WB, and the forward-priority helper.
// Ports   : none (package).
// Config  : REG_HAZARD_FORWARD_EN (consumed by reg_hazard_unit).
package reg_hazard_pkg;

   localparam int REG_IDX_W    = 6;
   localparam int MULDIV_CNT_W = 6;

   localparam logic [REG_IDX_W-1:0] HILO_REG = 6'd33;

   localparam logic [1:0] FWD_REGFILE = 2'd0;
   localparam logic [1:0] FWD_EXMEM   = 2'd1;
   localparam logic [1:0] FWD_MEMWB   = 2'd2;

   typedef struct packed {
      logic                 valid;
      logic [REG_IDX_W-1:0] wr;
      logic                 load;
   } tag_slot_t;

   localparam tag_slot_t TAG_BUBBLE = '{valid: 1'b0, wr: '0, load: 1'b0};

   // The younger producer (EX) holds the newest value, so it beats MEM.
   function automatic logic [1:0] fwd_select(input logic hit_ex, input logic hit_mem);
      if (hit_ex)
         return FWD_EXMEM;
      else if (hit_mem)
         return FWD_MEMWB;
      else
         return FWD_REGFILE;
   endfunction

endpackage

// File: rtl/reg_hazard_unit_tag_cmp.sv
// rtl/reg_hazard_unit_tag_cmp.sv - two read indices against one in-flight tag slot
//
// Purpose : hazard_tag_cmp; reports whether each ID read index matches a slot.
//           Index 0 never matches, so a slot with wr==0 never matches either.
// Ports   : rr1, rr2    - ID read indices
//           slot_valid  - slot holds a real instruction
//           slot_wr     - slot destination index
//           hit1, hit2  - rr1 / rr2 match the slot
module hazard_tag_cmp
   import reg_hazard_pkg::*;
(
   input  logic [REG_IDX_W-1:0] rr1,
   input  logic [REG_IDX_W-1:0] rr2,
   input  logic                 slot_valid,
   input  logic [REG_IDX_W-1:0] slot_wr,
   output logic                 hit1,
   output logic                 hit2
);

   assign hit1 = slot_valid && (rr1 != '0) && (rr1 == slot_wr);
   assign hit2 = slot_valid && (rr2 != '0) && (rr2 == slot_wr);

endmodule

// File: rtl/reg_hazard_unit.sv
// rtl/reg_hazard_unit.sv - ID-stage data-hazard scoreboard with stall and forward selects
//
// Purpose : tracks destination tags through EX/MEM/WB, raises load-use and
//           HI/LO-busy stalls, registers EX operand forward selects.
// Config  : REG_HAZARD_FORWARD_EN - when defined, EX/MEM and MEM/WB forwarding is
//           used; otherwise forward selects stay 0 and any EX/MEM match stalls.
// Params  : MULDIV_LAT   - cycles the HI/LO unit stays busy after a muldiv enters EX (1..63)
// Ports   : clk, rst     - clock, synchronous active-high reset
//           id_valid     - ID instruction is real
//           id_rr1/2     - ID read indices
//           id_wr        - ID write index (0 = none)
//           id_is_load   - ID instruction is a load
//           id_is_muldiv - ID instruction is MULTU/DIVU
//           flush        - kill ID, EX and MEM
//           stall        - hold IF/ID, bubble into EX (combinational)
//           ex_fwd_a/b   - registered operand source for the instruction in EX
//           muldiv_busy  - HI/LO unit counter non-zero
module reg_hazard_unit
   import reg_hazard_pkg::*;
#(
   parameter int MULDIV_LAT = 4
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [REG_IDX_W-1:0] id_rr1,
   input  logic [REG_IDX_W-1:0] id_rr2,
   input  logic [REG_IDX_W-1:0] id_wr,
   input  logic                 id_is_load,
   input  logic                 id_is_muldiv,
   input  logic                 flush,
   output logic                 stall,
   output logic [1:0]           ex_fwd_a,
   output logic [1:0]           ex_fwd_b,
   output logic                 muldiv_busy
);

   localparam logic [MULDIV_CNT_W-1:0] LAT_LOAD = MULDIV_CNT_W'(MULDIV_LAT);

   tag_slot_t                 ex_slot;
   tag_slot_t                 mem_slot;
   tag_slot_t                 wb_slot;
   logic [MULDIV_CNT_W-1:0]   muldiv_cnt;

   logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
   logic data_hazard, hilo_conflict, issue;

   hazard_tag_cmp u_cmp_ex (
      .rr1        (id_rr1),
      .rr2        (id_rr2),
      .slot_valid (ex_slot.valid),
      .slot_wr    (ex_slot.wr),
      .hit1       (ex_hit1),
      .hit2       (ex_hit2)
   );

   hazard_tag_cmp u_cmp_mem (
      .rr1        (id_rr1),
      .rr2        (id_rr2),
      .slot_valid (mem_slot.valid),
      .slot_wr    (mem_slot.wr),
      .hit1       (mem_hit1),
      .hit2       (mem_hit2)
   );

`ifdef REG_HAZARD_FORWARD_EN
   // Only a load in EX cannot be forwarded in time.
   assign data_hazard = (ex_hit1 || ex_hit2) && ex_slot.load;
`else
   // Without forwarding the consumer waits until the producer reaches WB.
   assign data_hazard = ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2;
`endif

   assign muldiv_busy = (muldiv_cnt != '0);

   // A muldiv implicitly writes HI/LO, so it also waits for the unit.
   assign hilo_conflict = muldiv_busy &&
                          ((id_rr1 == HILO_REG) || (id_rr2 == HILO_REG) ||
                           (id_wr == HILO_REG) || id_is_muldiv);

   assign stall = id_valid && !flush && (data_hazard || hilo_conflict);
   assign issue = id_valid && !flush && !stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_slot  <= TAG_BUBBLE;
         mem_slot <= TAG_BUBBLE;
         wb_slot  <= TAG_BUBBLE;
      end else begin
         wb_slot  <= mem_slot;
         mem_slot <= flush ? TAG_BUBBLE : ex_slot;
         if (issue)
            ex_slot <= '{valid: 1'b1, wr: id_wr, load: id_is_load};
         else
            ex_slot <= TAG_BUBBLE;
      end
   end

   // Flush leaves the counter alone: a muldiv already in the unit still completes.
   always_ff @(posedge clk) begin
      if (rst)
         muldiv_cnt <= '0;
      else if (issue && id_is_muldiv)
         muldiv_cnt <= LAT_LOAD;
      else if (muldiv_cnt != '0)
         muldiv_cnt <= muldiv_cnt - 1'b1;
   end

`ifdef REG_HAZARD_FORWARD_EN
   always_ff @(posedge clk) begin
      if (rst || !issue) begin
         ex_fwd_a <= FWD_REGFILE;
         ex_fwd_b <= FWD_REGFILE;
      end else begin
         ex_fwd_a <= fwd_select(ex_hit1, mem_hit1);
         ex_fwd_b <= fwd_select(ex_hit2, mem_hit2);
      end
   end
`else
   assign ex_fwd_a = FWD_REGFILE;
   assign ex_fwd_b = FWD_REGFILE;
`endif

   // WB is tracked for pipeline bookkeeping but needs no compare: the regfile
   // writes before it is read. MEM's load flag likewise has no consumer.
   logic unused_tag_bits;
   assign unused_tag_bits = ^{wb_slot, mem_slot.load};

endmodule

// File: tb/tb_reg_hazard_unit.sv
// tb/tb_reg_hazard_unit.sv - scoreboard bench for reg_hazard_unit
module tb_reg_hazard_unit;

   localparam int LAT = 4;
`ifdef REG_HAZARD_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [5:0] id_rr1, id_rr2, id_wr;
   logic       id_is_load, id_is_muldiv, flush;
   logic       stall;
   logic [1:0] ex_fwd_a, ex_fwd_b;
   logic       muldiv_busy;

   reg_hazard_unit #(.MULDIV_LAT(LAT)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rr1       (id_rr1),
      .id_rr2       (id_rr2),
      .id_wr        (id_wr),
      .id_is_load   (id_is_load),
      .id_is_muldiv (id_is_muldiv),
      .flush        (flush),
      .stall        (stall),
      .ex_fwd_a     (ex_fwd_a),
      .ex_fwd_b     (ex_fwd_b),
      .muldiv_busy  (muldiv_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [1:0] fa;
      logic [1:0] fb;
      logic       busy;
   } exp_t;
   exp_t sb[$];

   // Reference model: index 0 = EX, 1 = MEM, 2 = WB
   bit         mv[3];
   logic [5:0] mw[3];
   bit         ml[3];
   int         mcnt;
   bit         obs_stall;

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mv[i] = 1'b0;
         mw[i] = '0;
         ml[i] = 1'b0;
      end
      mcnt = 0;
   endtask

   function automatic bit hit(input logic [5:0] r, input int i);
      return mv[i] && (r != 6'd0) && (r == mw[i]);
   endfunction

   function automatic logic [1:0] msel(input logic [5:0] r);
      if (!FWD) return 2'd0;
      if (hit(r, 0)) return 2'd1;
      if (hit(r, 1)) return 2'd2;
      return 2'd0;
   endfunction

   function automatic bit model_stall(input bit v, input logic [5:0] r1, input logic [5:0] r2,
                                      input logic [5:0] w, input bit md, input bit fl);
      bit dh, hl;
      if (FWD)
         dh = (hit(r1, 0) || hit(r2, 0)) && ml[0];
      else
         dh = hit(r1, 0) || hit(r2, 0) || hit(r1, 1) || hit(r2, 1);
      hl = (mcnt != 0) && (r1 == 6'd33 || r2 == 6'd33 || w == 6'd33 || md);
      return v && !fl && (dh || hl);
   endfunction

   task automatic step(input bit v, input logic [5:0] r1, input logic [5:0] r2,
                       input logic [5:0] w, input bit ld, input bit md,
                       input bit fl, input bit rs);
      exp_t e, got;
      bit   es, en;
      @(negedge clk);
      id_valid     = v;
      id_rr1       = r1;
      id_rr2       = r2;
      id_wr        = w;
      id_is_load   = ld;
      id_is_muldiv = md;
      flush        = fl;
      rst          = rs;
      #1;
      es = model_stall(v, r1, r2, w, md, fl);
      check("stall", stall, es);
      obs_stall = stall;
      en = v && !fl && !es;
      e.fa = en ? msel(r1) : 2'd0;
      e.fb = en ? msel(r2) : 2'd0;
      if (rs) begin
         model_reset();
         e.fa = 2'd0;
         e.fb = 2'd0;
      end else begin
         mv[2] = mv[1]; mw[2] = mw[1]; ml[2] = ml[1];
         mv[1] = fl ? 1'b0 : mv[0];
         mw[1] = mw[0];
         ml[1] = ml[0];
         mv[0] = en;
         mw[0] = en ? w : 6'd0;
         ml[0] = en && ld;
         if (en && md)
            mcnt = LAT;
         else if (mcnt > 0)
            mcnt = mcnt - 1;
      end
      e.busy = (mcnt != 0);
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_underflow", 1, 0);
      end else begin
         got = sb.pop_front();
         check("fwd_a", ex_fwd_a, got.fa);
         check("fwd_b", ex_fwd_b, got.fb);
         check("busy", muldiv_busy, got.busy);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Repeat an ID instruction until it issues; returns number of stalled cycles.
   task automatic issue_until(input logic [5:0] r1, input logic [5:0] r2,
                              input logic [5:0] w, output int n);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step(1, r1, r2, w, 0, 0, 0, 0);
         if (!obs_stall) break;
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; id_valid = 0; id_rr1 = 0; id_rr2 = 0; id_wr = 0;
      id_is_load = 0; id_is_muldiv = 0; flush = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_fwd_a", ex_fwd_a, 0);
      check("rst_fwd_b", ex_fwd_b, 0);
      check("rst_busy", muldiv_busy, 0);
      check("rst_stall", stall, 0);

      // independent instruction, empty slots
      step(1, 8, 9, 10, 0, 0, 0, 0);
      check("empty_stall", obs_stall, 0);
      idle(3);

      // ALU producer, back-to-back consumer
      step(1, 1, 2, 8, 0, 0, 0, 0);
      issue_until(8, 8, 11, n);
      check("alu_b2b_stalls", n, FWD ? 0 : 2);
      check("alu_b2b_fwd_a", ex_fwd_a, FWD ? 1 : 0);
      check("alu_b2b_fwd_b", ex_fwd_b, FWD ? 1 : 0);
      idle(3);

      // ALU producer, one-instruction gap
      step(1, 1, 2, 8, 0, 0, 0, 0);
      idle(1);
      issue_until(8, 8, 11, n);
      check("alu_gap_stalls", n, FWD ? 0 : 1);
      check("alu_gap_fwd_a", ex_fwd_a, FWD ? 2 : 0);
      idle(3);

      // load-use
      step(1, 1, 2, 5, 1, 0, 0, 0);
      issue_until(6, 5, 7, n);
      check("lw_stalls", n, FWD ? 1 : 2);
      check("lw_fwd_b", ex_fwd_b, FWD ? 2 : 0);
      check("lw_fwd_a", ex_fwd_a, 0);
      idle(3);

      // MULTU then MFLO
      step(1, 4, 5, 33, 0, 1, 0, 0);
      check("multu_busy", muldiv_busy, 1);
      issue_until(33, 0, 12, n);
      check("mflo_stalls", n, LAT);
      check("mflo_busy_after", muldiv_busy, 0);
      idle(3);

      // index 0 never matches, even a valid load with wr=0
      step(1, 1, 2, 0, 1, 0, 0, 0);
      step(1, 0, 0, 3, 0, 0, 0, 0);
      check("zero_stall", obs_stall, 0);
      check("zero_fwd_a", ex_fwd_a, 0);
      idle(3);

      // flush with a load-use pending, counter running
      step(1, 4, 5, 33, 0, 1, 0, 0);
      step(1, 1, 2, 7, 1, 0, 0, 0);
      step(1, 7, 0, 9, 0, 0, 1, 0);
      check("flush_stall", obs_stall, 0);
      check("flush_busy_kept", muldiv_busy, 1);
      step(1, 7, 7, 9, 0, 0, 0, 0);
      check("post_flush_stall", obs_stall, 0);
      check("post_flush_fwd_a", ex_fwd_a, 0);
      idle(6);

      // reset with load in EX and counter at 3
      step(1, 4, 5, 33, 0, 1, 0, 0);
      step(1, 1, 2, 3, 1, 0, 0, 0);
      step(1, 3, 0, 4, 0, 0, 0, 1);
      step(1, 3, 0, 4, 0, 0, 0, 0);
      check("post_rst_stall", obs_stall, 0);
      check("post_rst_busy", muldiv_busy, 0);
      check("post_rst_fwd_a", ex_fwd_a, 0);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         logic [5:0] pick [5];
         logic [5:0] r1, r2, w;
         bit v, ld, md, fl, rs;
         pick[0] = 6'd0; pick[1] = 6'd1; pick[2] = 6'd2; pick[3] = 6'd3; pick[4] = 6'd33;
         r1 = pick[$urandom_range(0, 4)];
         r2 = pick[$urandom_range(0, 4)];
         w  = pick[$urandom_range(0, 3)];
         v  = ($urandom_range(0, 3) != 0);
         ld = ($urandom_range(0, 2) == 0);
         md = ($urandom_range(0, 7) == 0);
         if (md) begin
            w  = 6'd33;
            ld = 1'b0;
         end
         fl = ($urandom_range(0, 15) == 0);
         rs = ($urandom_range(0, 63) == 0);
         step(v, r1, r2, w, ld, md, fl, rs);
      end

      check("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
